alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Sequencer for the M-extension operations of the execute stage.
- MUL is issued to the shared single-cycle ALU through a dedicated operand/control port, and the ALU's result is captured.
- DIV, REM, DIVU and REMU run as an internal 32-iteration restoring shift-subtract engine.
- Presents a valid/ready request/response handshake to the pipeline and holds one operation in flight.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; the 6-bit iteration counter assumes it.
- DIV_ITERS, 32, number of division iterations. Must equal XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  4  operation code: 1000 MUL, 1001 DIV, 1010 REM, 1011 DIVU, 1100 REMU
- req_a  in  32  operand A (dividend / multiplicand)
- req_b  in  32  operand B (divisor / multiplier)
- kill  in  1  synchronous abort (pipeline flush)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  32  result
- busy  out  1  high in any state other than IDLE
- alu_a  out  32  operand A driven to the shared ALU
- alu_b  out  32  operand B driven to the shared ALU
- alu_ctrl  out  4  control code driven to the shared ALU
- alu_result  in  32  combinational result returned by the shared ALU
- perf_ops  out  32  completed-operation counter (see Optional Feature)
- perf_busy  out  32  busy-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - rsp_valid = 0, rsp_result = 0, busy = 0.
  - alu_a = 0, alu_b = 0, alu_ctrl = 4'b0000.
  - Iteration counter = 0; perf counters = 0.
  - req_ready = 1 one cycle after rst_n deasserts.
- req_ready = (state == IDLE) and not kill.
  - A request is accepted on the edge where req_valid && req_ready.
  - No request is accepted while a response is pending.
- State machine: IDLE, MUL, DIV, FIXUP, RESP.
- IDLE, on accept:
  - Opcode 1000 -> MUL.
  - Opcodes 1001-1100 with divisor == 0 -> RESP directly:
    - DIV/DIVU result = 32'hFFFFFFFF.
    - REM/REMU result = dividend.
  - DIV/REM with a = 32'h80000000 and b = 32'hFFFFFFFF -> RESP directly:
    - DIV result = 32'h80000000.
    - REM result = 0.
  - Any other opcode 1001-1100 -> DIV:
    - Load |a| and |b| for the signed ops, raw values for the unsigned ops.
    - Latch the quotient sign (a[31]^b[31]) and remainder sign (a[31]); signs are used for DIV/REM only.
    - Counter = 31.
  - Any opcode other than 1000-1100 -> RESP with result 0.
- MUL (1 cycle):
  - alu_a = a, alu_b = b, alu_ctrl = 4'b1000, all registered at accept.
  - Next edge captures alu_result into rsp_result -> RESP.
  - alu_ctrl returns to 4'b0000 in every other state.
- DIV (32 cycles), each cycle:
  - {rem, quo} shifted left by 1.
  - If rem >= divisor: rem -= divisor and quo[0] = 1.
  - Counter decrements; counter == 0 -> FIXUP.
  - The remainder register is 33 bits, so no overflow occurs.
- FIXUP (1 cycle):
  - Apply two's-complement negation per the latched signs.
  - Select quo for DIV/DIVU and rem for REM/REMU -> RESP.
- RESP:
  - rsp_valid = 1; rsp_result is held stable.
  - On rsp_ready -> IDLE and rsp_valid drops on that edge.
  - A new request can be accepted the cycle after.
- Latency, from accept edge to first cycle with rsp_valid high:
  - MUL: 2 cycles.
  - Normal divide: 34 cycles.
  - Divide-by-zero, signed overflow, illegal opcode: 1 cycle.
- kill:
  - In any state, forces IDLE on the next edge.
  - Discards the in-flight operation and its pending response; rsp_valid drops.
  - kill with req_valid in the same cycle: the request is not accepted.
  - kill in IDLE has no effect.
- rsp_ready held high while the block is not in RESP has no effect.
- Reset mid-operation aborts immediately; no response is produced.

Optional Feature:
- Macro: ALU_MULDIV_PERF_EN.
- Defined:
  - perf_ops increments on each response handshake (rsp_valid && rsp_ready).
  - perf_busy increments every cycle busy is high.
  - Both counters wrap at 2^32 and are cleared by reset only.
  - Killed operations count toward perf_busy but not toward perf_ops.
- Undefined: perf_ops and perf_busy are constant 0 and the counter flops are absent.

Test Plan:
- MUL a=7, b=6, rsp_ready=1:
  - alu_ctrl = 1000 for exactly one cycle.
  - With a model ALU attached, rsp_result = 42 (32'h2A).
  - rsp_valid 2 cycles after accept.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> result 32'hFFFFFFFD (-3), 34 cycles. REM with the same operands -> 32'hFFFFFFFF (-1).
- DIVU a=32'hFFFFFFFF, b=16 -> result 32'h0FFFFFFF. REMU with the same operands -> 32'hF.
- Divide-by-zero: DIVU a=5, b=0 -> 32'hFFFFFFFF; REM a=5, b=0 -> 5; each 1-cycle latency.
- Signed overflow: DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000 with 1-cycle latency.
- Handshake, kill and reset:
  - rsp_ready held low 10 cycles -> rsp_result stable and req_ready = 0 throughout.
  - kill at DIV iteration 5 -> IDLE next cycle, no rsp_valid.
  - rst_n low during MUL -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// M-extension sequencer: MUL via the shared ALU, DIV/REM/DIVU/REMU via a restoring divider.
// Define ALU_MULDIV_PERF_EN to build the perf_ops/perf_busy counters; otherwise they read 0.
module alu_muldiv_seq #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_busy
);
    localparam logic [3:0] OpMul  = 4'b1000;
    localparam logic [3:0] OpDiv  = 4'b1001;
    localparam logic [3:0] OpRem  = 4'b1010;
    localparam logic [3:0] OpDivu = 4'b1011;
    localparam logic [3:0] OpRemu = 4'b1100;
    localparam logic [3:0] CtrlNop = 4'b0000;
    localparam logic [5:0] LastIter = 6'(DIV_ITERS - 1);
    localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFixup, StResp} state_e;

    state_e          state;
    logic            ready_en;
    logic [5:0]      iter;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor;
    logic            neg_quo;
    logic            neg_rem;
    logic            want_rem;

    logic            accept;
    logic            is_signed;
    logic            is_rem_op;
    logic            is_div_op;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN+1:0] rem_shift;
    logic [XLEN+1:0] rem_sub;
    logic            rem_ge;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // ready_en keeps req_ready low until the first edge after reset release
    assign req_ready = ready_en && (state == StIdle) && !kill;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == StResp);
    assign busy      = (state != StIdle);

    assign is_signed = (req_op == OpDiv) || (req_op == OpRem);
    assign is_rem_op = (req_op == OpRem) || (req_op == OpRemu);
    assign is_div_op = is_signed || (req_op == OpDivu) || (req_op == OpRemu);
    assign abs_a     = (is_signed && req_a[XLEN-1]) ? (0 - req_a) : req_a;
    assign abs_b     = (is_signed && req_b[XLEN-1]) ? (0 - req_b) : req_b;

    // Both operands are non-negative, so a clear MSB after subtracting means rem >= divisor
    assign rem_shift = {rem, quo[XLEN-1]};
    assign rem_sub   = rem_shift - {2'b00, divisor};
    assign rem_ge    = !rem_sub[XLEN+1];

    assign quo_fix = neg_quo ? (0 - quo) : quo;
    assign rem_fix = neg_rem ? (0 - rem[XLEN-1:0]) : rem[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            ready_en   <= 1'b0;
            iter       <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            want_rem   <= 1'b0;
            rsp_result <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= CtrlNop;
        end else begin
            ready_en <= 1'b1;
            alu_ctrl <= CtrlNop;
            if (kill) begin
                state <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (accept) begin
                            if (req_op == OpMul) begin
                                alu_a    <= req_a;
                                alu_b    <= req_b;
                                alu_ctrl <= OpMul;
                                state    <= StMul;
                            end else if (is_div_op && req_b == '0) begin
                                rsp_result <= is_rem_op ? req_a : '1;
                                state      <= StResp;
                            end else if (is_signed && req_a == IntMin && req_b == '1) begin
                                rsp_result <= is_rem_op ? '0 : IntMin;
                                state      <= StResp;
                            end else if (is_div_op) begin
                                rem      <= '0;
                                quo      <= abs_a;
                                divisor  <= abs_b;
                                neg_quo  <= is_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
                                neg_rem  <= is_signed && req_a[XLEN-1];
                                want_rem <= is_rem_op;
                                iter     <= LastIter;
                                state    <= StDiv;
                            end else begin
                                rsp_result <= '0;
                                state      <= StResp;
                            end
                        end
                    end
                    StMul: begin
                        rsp_result <= alu_result;
                        state      <= StResp;
                    end
                    StDiv: begin
                        rem  <= rem_ge ? rem_sub[XLEN:0] : rem_shift[XLEN:0];
                        quo  <= {quo[XLEN-2:0], rem_ge};
                        iter <= iter - 6'd1;
                        if (iter == '0) state <= StFixup;
                    end
                    StFixup: begin
                        rsp_result <= want_rem ? rem_fix : quo_fix;
                        state      <= StResp;
                    end
                    StResp: begin
                        if (rsp_ready) state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

`ifdef ALU_MULDIV_PERF_EN
    logic [31:0] ops_cnt;
    logic [31:0] busy_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_cnt  <= '0;
            busy_cnt <= '0;
        end else begin
            if (rsp_valid && rsp_ready) ops_cnt <= ops_cnt + 32'd1;
            if (busy) busy_cnt <= busy_cnt + 32'd1;
        end
    end

    assign perf_ops  = ops_cnt;
    assign perf_busy = busy_cnt;
`else
    assign perf_ops  = '0;
    assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq with a behavioural shared-ALU model.
module tb_alu_muldiv_seq;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [31:0] perf_ops;
    logic [31:0] perf_busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_muldiv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .kill      (kill),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .busy      (busy),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_result(alu_result),
        .perf_ops  (perf_ops),
        .perf_busy (perf_busy)
    );

    // Shared ALU model: multiplies on 1000, otherwise returns zero
    assign alu_result = (alu_ctrl == 4'b1000) ? alu_a * alu_b : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        check("accept_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_rsp(output int lat, output int ctrl_cycles);
        lat = 1;
        ctrl_cycles = 0;
        while (lat < 100) begin
            if (alu_ctrl == 4'b1000) ctrl_cycles++;
            if (rsp_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        check("ready_after_rsp", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int ctrl_cycles;
        issue(op, a, b);
        wait_rsp(lat, ctrl_cycles);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_alu_ctrl_cycles"}, ctrl_cycles, (op == 4'b1000) ? 1 : 0);
        check({tag, "_result"}, rsp_result, exp_res);
        finish_rsp();
    endtask

    initial begin
        int lat;
        int ctrl_cycles;
        logic seen;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'b0;
        req_a     = '0;
        req_b     = '0;
        kill      = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
        check("rst_perf_ops", perf_ops, 32'h0);
        check("rst_perf_busy", perf_busy, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // MUL with rsp_ready held high beforehand
        rsp_ready = 1'b1;
        run_op("mul_7x6", 4'b1000, 32'd7, 32'd6, 32'h2A, 2);
        rsp_ready = 1'b0;

        run_op("div_m7_2",   4'b1001, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run_op("rem_m7_2",   4'b1010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run_op("divu_max16", 4'b1011, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 34);
        run_op("remu_max16", 4'b1100, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 34);
        run_op("div_100_m7", 4'b1001, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34);
        run_op("rem_100_m7", 4'b1010, 32'd100, 32'hFFFFFFF9, 32'd2, 34);
        run_op("divu_min_3", 4'b1011, 32'h80000000, 32'd3, 32'h2AAAAAAA, 34);
        run_op("remu_min_3", 4'b1100, 32'h80000000, 32'd3, 32'd2, 34);
        run_op("divu_by0",   4'b1011, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_op("rem_by0",    4'b1010, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf",    4'b1001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",    4'b1010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
        run_op("illegal_3",  4'b0011, 32'd9, 32'd9, 32'h0, 1);
        run_op("illegal_d",  4'b1101, 32'd9, 32'd9, 32'h0, 1);

        // Backpressure: response held, new requests refused
        issue(4'b1000, 32'd3, 32'd5);
        wait_rsp(lat, ctrl_cycles);
        check("hold_lat", lat, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = 4'b1011;
            req_a     = 32'd77;
            req_b     = 32'd7;
            @(posedge clk);
            #1;
            check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_result", rsp_result, 32'd15);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        finish_rsp();

        // kill mid-divide, with a competing request in the kill cycle
        issue(4'b1001, 32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        kill      = 1'b1;
        req_valid = 1'b1;
        req_op    = 4'b1000;
        req_a     = 32'd2;
        req_b     = 32'd2;
        #1;
        check("kill_blocks_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        kill      = 1'b0;
        req_valid = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'd0);
        check("kill_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy || alu_ctrl != 4'b0000) seen = 1'b1;
        end
        check("kill_no_activity", {31'b0, seen}, 32'd0);

        // kill while a response is pending
        issue(4'b0000, 32'd1, 32'd1);
        check("kresp_valid", {31'b0, rsp_valid}, 32'd1);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kresp_dropped", {31'b0, rsp_valid}, 32'd0);

        run_op("after_kill_divu", 4'b1011, 32'd100, 32'd7, 32'd14, 34);

        // Asynchronous reset during MUL
        issue(4'b1000, 32'd9, 32'd9);
        check("mul_ctrl_before_rst", {28'b0, alu_ctrl}, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_result", rsp_result, 32'h0);
        check("arst_alu_a", alu_a, 32'h0);
        check("arst_alu_b", alu_b, 32'h0);
        check("arst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
        check("arst_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) seen = 1'b1;
        end
        check("arst_no_rsp", {31'b0, seen}, 32'd0);
        check("arst_ready", {31'b0, req_ready}, 32'd1);

`ifndef ALU_MULDIV_PERF_EN
        check("perf_ops_off", perf_ops, 32'h0);
        check("perf_busy_off", perf_busy, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
